dmem_responder: RTL and testbench

Responder end of the Mem-stage data-memory interface. It accepts one load or store request at a time from the pipeline's memory-stage initiator over a valid/ready handshake and services it against an internal word-addressed RAM after a fixed, configurable latency. It returns read data and an error flag over a second valid/ready handshake. It is the multi-cycle replacement for the single-cycle data memory and is the target used to verify a stalling Mem stage.

---
 rtl/dmem_responder.sv | 169 ++++++++++++++++
 tb/tb_dmem_responder.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//   Responder end of the Mem-stage data-memory interface. It takes one load or
//   store at a time over a valid/ready request channel. The access is serviced
//   against an internal word-addressed RAM a fixed LATENCY edges after the
//   request is accepted. Read data and an error flag are then returned over a
//   valid/ready response channel. Requests never overlap, so a load that
//   follows a store always sees the stored data without any forwarding.
//
// Parameters
//   DEPTH    number of 32-bit RAM words (power of 2, >= 4); word = reqAddr[31:2]
//   LATENCY  edges from request acceptance to respValid rising (>= 1)
//
// Ports
//   CLK        clock, rising edge
//   RST        synchronous active-high reset (also clears the RAM)
//   reqValid   request present
//   reqWrite   1 = store, 0 = load
//   reqAddr    byte address
//   reqWData   store data
//   reqReady   responder idle and able to accept (registered)
//   respValid  response present
//   respRData  load data; 0 for stores and errors
//   respErr    misaligned or out-of-range request
//   respReady  initiator takes the response this cycle
// ---------------------------------------------------------------------------
module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        reqValid,
  input  logic        reqWrite,
  input  logic [31:0] reqAddr,
  input  logic [31:0] reqWData,
  output logic        reqReady,
  output logic        respValid,
  output logic [31:0] respRData,
  output logic        respErr,
  input  logic        respReady
);

  localparam int          AW      = $clog2(DEPTH);
  // $clog2(LATENCY) bits always hold LATENCY-1; keep at least one bit.
  localparam int          CW      = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dmemReq_t;

  state_t          state, stateNext;
  dmemReq_t        capReq;
  logic [CW-1:0]   cnt;
  logic [31:0]     ram [DEPTH];

  logic            accept;
  logic            commit;
  logic            respDone;
  logic            misaligned;
  logic            inRange;
  logic            accErr;
  logic [AW-1:0]   wordIdx;
  logic [31:0]     ramRdData;

  // -------------------------------------------------------------------------
  // Access decode on the captured request. The range test is done over the
  // full 30-bit word index so high address bits never alias into the RAM.
  // -------------------------------------------------------------------------
  always_comb begin
    misaligned = (capReq.addr[1:0] != 2'b00);
    inRange    = ({2'b00, capReq.addr[31:2]} < DEPTH_W);
    accErr     = misaligned || !inRange;
    wordIdx    = capReq.addr[AW+1:2];
    ramRdData  = ram[wordIdx];
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    commit    = 1'b0;
    respDone  = 1'b0;
    case (state)
      IDLE: begin
        if (reqValid) begin
          accept    = 1'b1;
          stateNext = WAIT;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          commit    = 1'b1;
          stateNext = RESP;
        end
      end
      RESP: begin
        // respValid is always 1 in RESP, so respReady alone completes it.
        if (respReady) begin
          respDone  = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Control and response registers
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      reqReady  <= 1'b1;
      respValid <= 1'b0;
      respRData <= '0;
      respErr   <= 1'b0;
      cnt       <= '0;
      capReq    <= '0;
    end else begin
      state    <= stateNext;
      // Registered copy of "next state is IDLE": no input reaches reqReady
      // within the same cycle.
      reqReady <= (stateNext == IDLE);

      if (accept) begin
        capReq.write <= reqWrite;
        capReq.addr  <= reqAddr;
        capReq.wdata <= reqWData;
        cnt          <= CW'(LATENCY - 1);
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end

      if (commit) begin
        respValid <= 1'b1;
        respErr   <= accErr;
        respRData <= (!accErr && !capReq.write) ? ramRdData : 32'h0;
      end else if (respDone) begin
        respValid <= 1'b0;
        respErr   <= 1'b0;
        respRData <= '0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // RAM. Reset wipes every word; a store whose commit edge sees RST is lost.
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
    end else if (commit && capReq.write && !accErr) begin
      ram[wordIdx] <= capReq.wdata;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder. Instance 0 (LATENCY=2) carries the main
// functional sequence; instances 1 (LATENCY=1) and 2 (LATENCY=5) share the
// same inputs and are measured in the closing latency / throughput sweep.
module tb_dmem_responder;

  logic        CLK = 1'b0;
  logic        RST;
  logic        reqValid;
  logic        reqWrite;
  logic [31:0] reqAddr;
  logic [31:0] reqWData;
  logic        respReady;

  logic [2:0]       reqReadyV;
  logic [2:0]       respValidV;
  logic [2:0][31:0] respRDataV;
  logic [2:0]       respErrV;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  dmem_responder #(.DEPTH(256), .LATENCY(2)) dut2 (
    .CLK(CLK), .RST(RST), .reqValid(reqValid), .reqWrite(reqWrite),
    .reqAddr(reqAddr), .reqWData(reqWData), .reqReady(reqReadyV[0]),
    .respValid(respValidV[0]), .respRData(respRDataV[0]), .respErr(respErrV[0]),
    .respReady(respReady)
  );

  dmem_responder #(.DEPTH(256), .LATENCY(1)) dut1 (
    .CLK(CLK), .RST(RST), .reqValid(reqValid), .reqWrite(reqWrite),
    .reqAddr(reqAddr), .reqWData(reqWData), .reqReady(reqReadyV[1]),
    .respValid(respValidV[1]), .respRData(respRDataV[1]), .respErr(respErrV[1]),
    .respReady(respReady)
  );

  dmem_responder #(.DEPTH(256), .LATENCY(5)) dut5 (
    .CLK(CLK), .RST(RST), .reqValid(reqValid), .reqWrite(reqWrite),
    .reqAddr(reqAddr), .reqWData(reqWData), .reqReady(reqReadyV[2]),
    .respValid(respValidV[2]), .respRData(respRDataV[2]), .respErr(respErrV[2]),
    .respReady(respReady)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One request on instance 0. Drives are applied 1 time unit after an edge
  // and outputs are sampled there too. 'hold' cycles of respReady=0 follow
  // respValid rising, with reqValid pulsing to show it is ignored.
  task automatic doReq(input string tag, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] expData,
                       input logic expErr, input int hold);
    int n;
    respReady = (hold == 0);
    reqWrite  = wr;
    reqAddr   = addr;
    reqWData  = wd;
    reqValid  = 1'b1;
    check({tag, " reqReady"}, 32'(reqReadyV[0]), 32'd1);
    tick();                       // accept edge k
    reqValid = 1'b0;
    n = 0;
    while (!respValidV[0] && n < 20) begin
      tick();
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'd2);
    check({tag, " rdata"}, respRDataV[0], expData);
    check({tag, " err"}, 32'(respErrV[0]), 32'(expErr));
    for (int i = 0; i < hold; i++) begin
      reqValid = i[0];
      reqWrite = 1'b1;
      reqWData = 32'h0BAD0BAD;
      tick();
      check({tag, " hold valid"}, 32'(respValidV[0]), 32'd1);
      check({tag, " hold rdata"}, respRDataV[0], expData);
      check({tag, " hold err"}, 32'(respErrV[0]), 32'(expErr));
      check({tag, " hold reqReady"}, 32'(reqReadyV[0]), 32'd0);
    end
    reqValid  = 1'b0;
    respReady = 1'b1;
    tick();                       // response handshake edge
    check({tag, " done valid"}, 32'(respValidV[0]), 32'd0);
    check({tag, " done rdata"}, respRDataV[0], 32'h0);
    check({tag, " done reqReady"}, 32'(reqReadyV[0]), 32'd1);
  endtask

  int lat [3] = '{2, 1, 5};
  int acc [3];
  int nAcc [3];
  logic pv [3];

  initial begin
    RST       = 1'b1;
    reqValid  = 1'b0;
    reqWrite  = 1'b0;
    reqAddr   = '0;
    reqWData  = '0;
    respReady = 1'b1;

    // Reset for two cycles
    tick();
    tick();
    RST = 1'b0;
    check("rst reqReady", 32'(reqReadyV[0]), 32'd1);
    check("rst respValid", 32'(respValidV[0]), 32'd0);
    check("rst respRData", respRDataV[0], 32'h0);
    check("rst respErr", 32'(respErrV[0]), 32'd0);

    doReq("ld0", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 0);

    // Store then load
    doReq("st10", 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 0);
    doReq("ld10", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0);
    doReq("ld14", 1'b0, 32'h14, 32'h0, 32'h0, 1'b0, 0);

    // Backpressure: 5 stalled cycles, stray reqValid store pulses ignored
    doReq("bp", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 5);
    doReq("bp after", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0);

    // Errors
    doReq("st13 mis", 1'b1, 32'h13, 32'h11111111, 32'h0, 1'b1, 0);
    doReq("ld10 kept", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0);
    doReq("ld400 oor", 1'b0, 32'h400, 32'h0, 32'h0, 1'b1, 0);
    doReq("st400 oor", 1'b1, 32'h400, 32'h55555555, 32'h0, 1'b1, 0);
    doReq("ld0 noalias", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 0);
    doReq("ldhi oor", 1'b0, 32'h80000010, 32'h0, 32'h0, 1'b1, 0);
    doReq("ld11 mis", 1'b0, 32'h11, 32'h0, 32'h0, 1'b1, 0);
    doReq("ld3fc last", 1'b0, 32'h3FC, 32'h0, 32'h0, 1'b0, 0);

    // Reset on the commit edge of a store to 0x20
    reqWrite = 1'b1;
    reqAddr  = 32'h20;
    reqWData = 32'h12345678;
    reqValid = 1'b1;
    tick();                       // accept edge k
    reqValid = 1'b0;
    tick();                       // edge k+1
    RST = 1'b1;
    tick();                       // edge k+2: commit edge under reset
    RST = 1'b0;
    check("midrst respValid", 32'(respValidV[0]), 32'd0);
    check("midrst reqReady", 32'(reqReadyV[0]), 32'd1);
    doReq("midrst ld20", 1'b0, 32'h20, 32'h0, 32'h0, 1'b0, 0);
    doReq("midrst ld10 cleared", 1'b0, 32'h10, 32'h0, 32'h0, 1'b0, 0);

    // Latency / throughput sweep: all three instances, reqValid and
    // respReady held high.
    RST = 1'b1;
    tick();
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      acc[i]  = -1;
      nAcc[i] = 0;
      pv[i]   = 1'b0;
    end
    reqWrite  = 1'b0;
    reqAddr   = 32'h0;
    reqValid  = 1'b1;
    respReady = 1'b1;
    for (int n = 0; n < 40; n++) begin
      if (n > 0) tick();
      for (int i = 0; i < 3; i++) begin
        if (respValidV[i] && !pv[i])
          check($sformatf("sweep lat L%0d", lat[i]), 32'(n - acc[i]), 32'(lat[i]));
        pv[i] = respValidV[i];
        if (reqReadyV[i]) begin
          // accepted on the next edge
          if (acc[i] >= 0)
            check($sformatf("sweep gap L%0d", lat[i]), 32'(n + 1 - acc[i]), 32'(lat[i] + 2));
          acc[i] = n + 1;
          nAcc[i]++;
        end
      end
    end
    reqValid = 1'b0;
    for (int i = 0; i < 3; i++)
      check($sformatf("sweep accepts L%0d", lat[i]), 32'(nAcc[i] >= 4), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
